// File: rtl/mouse_packet_tracker_if.sv
// -----------------------------------------------------------------------------
// mouse_packet_tracker_if
// Groups the byte-receiver handshake and the tracker result bus.
//
// Handshake: BYTE_READY is a one-cycle valid strobe with no ready back-pressure
// on the byte itself; BYTE_READ/BYTE_ERROR_CODE are meaningful only in a cycle
// where BYTE_READY is high. READ_ENABLE is the level permit returned to the
// receiver. PACKET_VALID / PACKET_ERROR are one-cycle result strobes and are
// mutually exclusive.
//
// Signals:
//   ENABLE           tracking enable (to tracker)
//   BYTE_READ[7:0]   received byte (to tracker)
//   BYTE_ERROR_CODE  bit0 parity error, bit1 stop-bit error (to tracker)
//   BYTE_READY       byte strobe (to tracker)
//   READ_ENABLE      capture permit (from tracker)
//   MOUSE_X[8:0]     pointer X (from tracker)
//   MOUSE_Y[7:0]     pointer Y (from tracker)
//   MOUSE_STATUS     byte0 of last good packet (from tracker)
//   MOUSE_DX         raw byte1 of last good packet (from tracker)
//   MOUSE_DY         raw byte2 of last good packet (from tracker)
//   PACKET_VALID     position updated strobe (from tracker)
//   PACKET_ERROR     packet dropped strobe (from tracker)
//   STATE[1:0]       FSM state for debug (from tracker)
// -----------------------------------------------------------------------------
interface mouse_packet_tracker_if;
   logic       ENABLE;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       BYTE_READY;
   logic       READ_ENABLE;
   logic [8:0] MOUSE_X;
   logic [7:0] MOUSE_Y;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       PACKET_VALID;
   logic       PACKET_ERROR;
   logic [1:0] STATE;

   // Byte source / consumer of results
   modport master (
      output ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
      input  READ_ENABLE, MOUSE_X, MOUSE_Y, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
             PACKET_VALID, PACKET_ERROR, STATE
   );

   // Tracker side
   modport slave (
      input  ENABLE, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
      output READ_ENABLE, MOUSE_X, MOUSE_Y, MOUSE_STATUS, MOUSE_DX, MOUSE_DY,
             PACKET_VALID, PACKET_ERROR, STATE
   );
endinterface

// File: rtl/mouse_packet_tracker.sv
// -----------------------------------------------------------------------------
// mouse_packet_tracker
// Assembles 3-byte PS/2 mouse packets (status, dx, dy) and integrates the
// movement into a clamped screen position.
//
// Ports:
//   CLK    single clock, rising edge
//   RESET  synchronous, active-high
//   bus    mouse_packet_tracker_if.slave (byte input, position/status output)
// -----------------------------------------------------------------------------
module mouse_packet_tracker #(
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119,
   parameter int X_INIT  = 80,
   parameter int Y_INIT  = 60,
   parameter int TIMEOUT = 100000
) (
   input logic                  CLK,
   input logic                  RESET,
   mouse_packet_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2,
      UPDATE  = 2'd3
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]      TIMEOUT_C = CW'(TIMEOUT);
   localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
   localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);

   state_t        state;
   logic [CW-1:0] idle_cnt;
   logic          read_en;
   logic [8:0]    pos_x;
   logic [7:0]    pos_y;
   logic [7:0]    out_status;
   logic [7:0]    out_dx;
   logic [7:0]    out_dy;
   logic          pkt_valid;
   logic          pkt_error;

   // Bytes of the packet being assembled; kept apart from the published
   // outputs so a dropped packet leaves those untouched.
   logic [7:0]    status_q;
   logic [7:0]    dx_q;
   logic [7:0]    dy_q;

   logic          byte_ok;
   logic [8:0]    dx9;
   logic [8:0]    dy9;
   logic signed [10:0] sum_x;
   logic signed [10:0] sum_y;
   logic [8:0]    next_x;
   logic [7:0]    next_y;

   assign byte_ok = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);

   // Movement is 9-bit two's complement (sign bit lives in the status byte);
   // an overflow flag zeroes that axis. Sums are done 11-bit signed so the
   // clamp sees true out-of-range values rather than wrapped ones.
   always_comb begin
      dx9    = status_q[6] ? 9'd0 : {status_q[4], dx_q};
      dy9    = status_q[7] ? 9'd0 : {status_q[5], dy_q};
      sum_x  = $signed({2'b00, pos_x}) + $signed({{2{dx9[8]}}, dx9});
      sum_y  = $signed({3'b000, pos_y}) - $signed({{2{dy9[8]}}, dy9});
      next_x = sum_x[8:0];
      next_y = sum_y[7:0];
      if (sum_x < 0)            next_x = 9'd0;
      else if (sum_x > X_MAX_S) next_x = X_MAX_S[8:0];
      if (sum_y < 0)            next_y = 8'd0;
      else if (sum_y > Y_MAX_S) next_y = Y_MAX_S[7:0];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= WAIT_B0;
         idle_cnt   <= '0;
         read_en    <= 1'b0;
         pos_x      <= 9'(X_INIT);
         pos_y      <= 8'(Y_INIT);
         out_status <= 8'd0;
         out_dx     <= 8'd0;
         out_dy     <= 8'd0;
         pkt_valid  <= 1'b0;
         pkt_error  <= 1'b0;
         status_q   <= 8'd0;
         dx_q       <= 8'd0;
         dy_q       <= 8'd0;
      end else begin
         read_en   <= bus.ENABLE;
         pkt_valid <= 1'b0;
         pkt_error <= 1'b0;
         if (!bus.ENABLE) begin
            // Silent drop of any partial packet; bytes ignored.
            state    <= WAIT_B0;
            idle_cnt <= '0;
         end else begin
            case (state)
               WAIT_B0: begin
                  idle_cnt <= '0;
                  // Only a clean byte with the always-one bit 3 can start a
                  // packet; anything else is discarded to resynchronise.
                  if (byte_ok && bus.BYTE_READ[3]) begin
                     status_q <= bus.BYTE_READ;
                     state    <= WAIT_B1;
                  end
               end
               WAIT_B1, WAIT_B2: begin
                  // A byte in the timeout cycle takes precedence.
                  if (bus.BYTE_READY) begin
                     idle_cnt <= '0;
                     if (!byte_ok) begin
                        pkt_error <= 1'b1;
                        state     <= WAIT_B0;
                     end else if (state == WAIT_B1) begin
                        dx_q  <= bus.BYTE_READ;
                        state <= WAIT_B2;
                     end else begin
                        dy_q  <= bus.BYTE_READ;
                        state <= UPDATE;
                     end
                  end else if (idle_cnt == TIMEOUT_C) begin
                     idle_cnt  <= '0;
                     pkt_error <= 1'b1;
                     state     <= WAIT_B0;
                  end else begin
                     idle_cnt <= idle_cnt + CW'(1);
                  end
               end
               UPDATE: begin
                  pos_x      <= next_x;
                  pos_y      <= next_y;
                  out_status <= status_q;
                  out_dx     <= dx_q;
                  out_dy     <= dy_q;
                  pkt_valid  <= 1'b1;
                  idle_cnt   <= '0;
                  state      <= WAIT_B0;
               end
               default: begin
                  state    <= WAIT_B0;
                  idle_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bus.READ_ENABLE  = read_en;
   assign bus.MOUSE_X      = pos_x;
   assign bus.MOUSE_Y      = pos_y;
   assign bus.MOUSE_STATUS = out_status;
   assign bus.MOUSE_DX     = out_dx;
   assign bus.MOUSE_DY     = out_dy;
   assign bus.PACKET_VALID = pkt_valid;
   assign bus.PACKET_ERROR = pkt_error;
   assign bus.STATE        = state;

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_packet_tracker
// Scoreboard bench: stimulus pushes expected packet results into exp_q, a
// monitor pops one entry per PACKET_VALID / PACKET_ERROR strobe.
// -----------------------------------------------------------------------------
module tb_mouse_packet_tracker;
   localparam int XM = 159;
   localparam int YM = 119;
   localparam int TO = 40;

   typedef struct packed {
      logic        err;
      logic [8:0]  x;
      logic [7:0]  y;
      logic [7:0]  st;
      logic [7:0]  dx;
      logic [7:0]  dy;
      logic [31:0] cyc;   // 0 = arrival cycle not checked
   } exp_t;
   localparam int W = $bits(exp_t);

   logic CLK;
   logic RESET;
   mouse_packet_tracker_if bus ();

   mouse_packet_tracker #(
      .X_MAX(XM), .Y_MAX(YM), .X_INIT(80), .Y_INIT(60), .TIMEOUT(TO)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] cyc = 32'd1;
   always @(posedge CLK) cyc <= cyc + 32'd1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // reference model: position and last good packet
   int mx, my, mst, mdx, mdy;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int sext9(input int sign, input int b);
      return sign != 0 ? b - 256 : b;
   endfunction

   task automatic model_reset();
      mx = 80; my = 60; mst = 0; mdx = 0; mdy = 0;
   endtask

   task automatic model_update(input logic [7:0] st, input logic [7:0] b1,
                               input logic [7:0] b2);
      int dx, dy;
      dx = st[6] ? 0 : sext9(int'(st[4]), int'(b1));
      dy = st[7] ? 0 : sext9(int'(st[5]), int'(b2));
      mx = clampi(mx + dx, 0, XM);
      my = clampi(my - dy, 0, YM);
      mst = int'(st); mdx = int'(b1); mdy = int'(b2);
   endtask

   task automatic push_exp(input logic err, input logic [31:0] at);
      exp_t e;
      e.err = err;
      e.x   = 9'(mx);
      e.y   = 8'(my);
      e.st  = 8'(mst);
      e.dx  = 8'(mdx);
      e.dy  = 8'(mdy);
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      exp_t e;
      if (!RESET && (bus.PACKET_VALID || bus.PACKET_ERROR)) begin
         check("pulse_exclusive", int'(bus.PACKET_VALID && bus.PACKET_ERROR), 0);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: valid=%0d error=%0d at cycle %0d, none expected",
                     bus.PACKET_VALID, bus.PACKET_ERROR, cyc);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind_err", int'(bus.PACKET_ERROR), int'(e.err));
            check("mouse_x", int'(bus.MOUSE_X), int'(e.x));
            check("mouse_y", int'(bus.MOUSE_Y), int'(e.y));
            check("mouse_status", int'(bus.MOUSE_STATUS), int'(e.st));
            check("mouse_dx", int'(bus.MOUSE_DX), int'(e.dx));
            check("mouse_dy", int'(bus.MOUSE_DY), int'(e.dy));
            if (e.cyc != 32'd0) check("pulse_cycle", int'(cyc), int'(e.cyc));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
   endtask

   // Drives one byte strobe; returns 1ns after the edge that sampled it.
   task automatic send_byte(input logic [7:0] b, input logic [1:0] ec);
      @(posedge CLK);
      #1;
      bus.BYTE_READ       = b;
      bus.BYTE_ERROR_CODE = ec;
      bus.BYTE_READY      = 1'b1;
      @(posedge CLK);
      #1;
      bus.BYTE_READY = 1'b0;
   endtask

   // err_at: 0 = good packet, 1 = error on byte1, 2 = error on byte2
   task automatic send_packet(input logic [7:0] st, input logic [7:0] b1,
                              input logic [7:0] b2, input int err_at,
                              input logic [1:0] ec, input int max_gap);
      send_byte(st, 2'b00);
      idle($urandom_range(0, max_gap));
      if (err_at == 1) begin
         send_byte(b1, ec);
         push_exp(1'b1, cyc);
         return;
      end
      send_byte(b1, 2'b00);
      idle($urandom_range(0, max_gap));
      if (err_at == 2) begin
         send_byte(b2, ec);
         push_exp(1'b1, cyc);
         return;
      end
      send_byte(b2, 2'b00);
      model_update(st, b1, b2);
      // result visible two cycles after the byte2 strobe cycle
      push_exp(1'b0, cyc + 32'd1);
      idle($urandom_range(0, max_gap));
   endtask

   task automatic settle();
      repeat (3) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      bus.ENABLE = 1'b1;
      bus.BYTE_READY = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      model_reset();
      check("rst_x", int'(bus.MOUSE_X), 80);
      check("rst_y", int'(bus.MOUSE_Y), 60);
      check("rst_state", int'(bus.STATE), 0);
      check("rst_pulses", int'({bus.PACKET_VALID, bus.PACKET_ERROR}), 0);
      check("rst_read_en", int'(bus.READ_ENABLE), 0);
      check("rst_status", int'({bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}), 0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("read_en_release", int'(bus.READ_ENABLE), 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int kind, err_at, x0;
      logic [7:0] st, b;
      RESET = 1'b1;
      bus.ENABLE = 1'b1;
      bus.BYTE_READ = 8'd0;
      bus.BYTE_ERROR_CODE = 2'b00;
      bus.BYTE_READY = 1'b0;
      model_reset();

      do_reset();

      // basic packet
      send_packet(8'h08, 8'h05, 8'h03, 0, 2'b00, 0);
      settle();
      check("basic_x", int'(bus.MOUSE_X), 85);
      check("basic_y", int'(bus.MOUSE_Y), 57);
      check("basic_status", int'(bus.MOUSE_STATUS), 8'h08);

      // negative movement
      do_reset();
      send_packet(8'h38, 8'hF6, 8'hFB, 0, 2'b00, 0);
      settle();
      check("neg_x", int'(bus.MOUSE_X), 70);
      check("neg_y", int'(bus.MOUSE_Y), 65);

      // clamping
      do_reset();
      send_packet(8'h08, 8'h46, 8'h00, 0, 2'b00, 1);   // X -> 150
      send_packet(8'h08, 8'h14, 8'h00, 0, 2'b00, 1);
      settle();
      check("clamp_x_max", int'(bus.MOUSE_X), 159);
      send_packet(8'h28, 8'h00, 8'hC9, 0, 2'b00, 1);   // Y -> 115
      send_packet(8'h28, 8'h00, 8'hEC, 0, 2'b00, 1);
      settle();
      check("clamp_y_max", int'(bus.MOUSE_Y), 119);
      send_packet(8'h18, 8'h66, 8'h00, 0, 2'b00, 1);   // X -> 5
      send_packet(8'h18, 8'hF0, 8'h00, 0, 2'b00, 1);
      settle();
      check("clamp_x_min", int'(bus.MOUSE_X), 0);
      send_packet(8'h08, 8'h00, 8'h7F, 0, 2'b00, 1);   // Y -> 0
      settle();
      check("clamp_y_min", int'(bus.MOUSE_Y), 0);
      send_packet(8'h48, 8'h05, 8'h00, 0, 2'b00, 1);   // X overflow
      settle();
      check("ovf_x", int'(bus.MOUSE_X), 0);

      // resync on junk byte
      x0 = mx;
      send_byte(8'h00, 2'b00);
      send_packet(8'h08, 8'h01, 8'h00, 0, 2'b00, 0);
      settle();
      check("resync_x", int'(bus.MOUSE_X), x0 + 1);

      // parity error on byte1, then a good packet
      send_packet(8'h08, 8'h10, 8'h00, 1, 2'b01, 0);
      settle();
      check("err_x_kept", int'(bus.MOUSE_X), x0 + 1);
      send_packet(8'h08, 8'h03, 8'h00, 0, 2'b00, 0);
      settle();
      check("after_err_x", int'(bus.MOUSE_X), x0 + 4);

      // timeout after byte0
      x0 = mx;
      send_byte(8'h08, 2'b00);
      push_exp(1'b1, 32'd0);
      idle(TO + 10);
      @(negedge CLK);
      check("timeout_state", int'(bus.STATE), 0);
      send_packet(8'h08, 8'h02, 8'h00, 0, 2'b00, 0);
      settle();
      check("after_timeout_x", int'(bus.MOUSE_X), x0 + 2);

      // ENABLE low mid-packet: silent drop
      send_byte(8'h08, 2'b00);
      send_byte(8'h05, 2'b00);
      @(posedge CLK);
      #1;
      bus.ENABLE = 1'b0;
      idle(2);
      send_byte(8'h00, 2'b00);   // ignored while disabled
      @(negedge CLK);
      check("dis_read_en", int'(bus.READ_ENABLE), 0);
      check("dis_state", int'(bus.STATE), 0);
      @(posedge CLK);
      #1;
      bus.ENABLE = 1'b1;
      send_packet(8'h08, 8'h01, 8'h00, 0, 2'b00, 0);
      settle();
      check("reen_x", int'(bus.MOUSE_X), x0 + 3);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            b = 8'($urandom) & 8'hF7;
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 2'($urandom_range(1, 3)));
            else send_byte(b, 2'b00);
         end else begin
            err_at = (kind == 1) ? 1 : (kind == 2) ? 2 : 0;
            st = 8'($urandom) | 8'h08;
            send_packet(st, 8'($urandom), 8'($urandom), err_at,
                        2'($urandom_range(1, 3)), 3);
         end
      end

      idle(10);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // hard bound on total run time
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mouse_packet_tracker.md
MOUSE_PACKET_TRACKER -- requirements
Module: mouse_packet_tracker

Interface
REQ-001 Parameters SHALL be as follows; X_MAX and X_INIT SHALL be below 512, and Y_MAX and Y_INIT below 256:
- X_MAX, 159, rightmost legal X coordinate.
- Y_MAX, 119, bottom legal Y coordinate.
- X_INIT, 80, X value after reset.
- Y_INIT, 60, Y value after reset.
- TIMEOUT, 100000, maximum idle CLK cycles allowed between bytes of one packet.
REQ-002 Ports SHALL be as follows:
- CLK, in, 1, single clock; all logic is on its rising edge.
- RESET, in, 1, synchronous, active-high.
- ENABLE, in, 1, tracking enable.
- BYTE_READ, in, 8, byte from the upstream PS/2 byte receiver.
- BYTE_ERROR_CODE, in, 2, bit0 = parity error, bit1 = stop-bit error.
- BYTE_READY, in, 1, one-cycle pulse: BYTE_READ and BYTE_ERROR_CODE are valid this cycle.
- READ_ENABLE, out, 1, to the receiver; permits byte capture.
- MOUSE_X, out, 9, pointer X position.
- MOUSE_Y, out, 8, pointer Y position.
- MOUSE_STATUS, out, 8, byte0 of the last good packet.
- MOUSE_DX, out, 8, raw byte1 of the last good packet.
- MOUSE_DY, out, 8, raw byte2 of the last good packet.
- PACKET_VALID, out, 1, one-cycle pulse: position updated.
- PACKET_ERROR, out, 1, one-cycle pulse: packet dropped.
- STATE, out, 2, current FSM state, for debug.
REQ-003 The block SHALL use one clock (CLK) and a synchronous, active-high reset (RESET).

Function
REQ-004 FSM states SHALL be WAIT_B0=0, WAIT_B1=1, WAIT_B2=2, UPDATE=3.
REQ-005 READ_ENABLE SHALL be ENABLE registered by one cycle.
REQ-006 WAIT_B0: on BYTE_READY with BYTE_ERROR_CODE==0 and BYTE_READ[3]==1, the block SHALL latch the byte as status and go to WAIT_B1. Otherwise the byte SHALL be discarded silently and the FSM stays in WAIT_B0 (resync).
REQ-007 WAIT_B1: on BYTE_READY with no error, the block SHALL latch dx and go to WAIT_B2.
REQ-008 WAIT_B2: on BYTE_READY with no error, the block SHALL latch dy and go to UPDATE.
REQ-009 In WAIT_B1 or WAIT_B2, a byte with nonzero BYTE_ERROR_CODE SHALL pulse PACKET_ERROR on the next cycle and return the FSM to WAIT_B0. Position and latched outputs SHALL be unchanged.
REQ-010 An idle counter SHALL reset on every BYTE_READY and on entry to WAIT_B0.
REQ-011 In WAIT_B1/WAIT_B2, when the idle counter reaches TIMEOUT, the block SHALL pulse PACKET_ERROR and return to WAIT_B0. If BYTE_READY arrives in the same cycle, the byte SHALL win and no timeout is taken.
REQ-012 ENABLE low SHALL force WAIT_B0 and drop any partial packet without a PACKET_ERROR pulse. BYTE_READY SHALL be ignored while ENABLE is low.
REQ-013 UPDATE (one cycle), X axis:
- dx = sign-extended {status[4], byte1} (9-bit two's complement).
- If status[6] (X overflow) is set, dx is treated as 0.
REQ-014 UPDATE, Y axis:
- dy = sign-extended {status[5], byte2}.
- If status[7] (Y overflow) is set, dy is treated as 0.
REQ-015 Position arithmetic SHALL be 11-bit signed, with no wrap-around:
- newX = X + dx, clamped to [0, X_MAX].
- newY = Y - dy (screen Y grows downward), clamped to [0, Y_MAX].
REQ-016 At the UPDATE edge the block SHALL load MOUSE_X/Y, MOUSE_STATUS, MOUSE_DX and MOUSE_DY, assert PACKET_VALID for exactly one cycle, and return to WAIT_B0.
REQ-017 Latency from the byte2 BYTE_READY cycle to MOUSE_X/Y and PACKET_VALID visible SHALL be 2 cycles.
REQ-018 PACKET_VALID and PACKET_ERROR SHALL never be high together.
REQ-019 A BYTE_READY during UPDATE SHALL be ignored; the upstream receiver cannot deliver bytes that close together.

Reset
REQ-020 While RESET is high at a CLK edge, the block SHALL set:
- STATE = WAIT_B0.
- MOUSE_X = X_INIT and MOUSE_Y = Y_INIT.
- MOUSE_STATUS, MOUSE_DX and MOUSE_DY = 0.
- PACKET_VALID, PACKET_ERROR and READ_ENABLE = 0.
- Idle counter = 0.
REQ-021 RESET mid-packet SHALL discard the partial packet with no pulse. RESET SHALL take priority over every other input.

Verification
REQ-022 Reset with ENABLE=1 -> MOUSE_X=80, MOUSE_Y=60, STATE=0, all pulses 0; READ_ENABLE=1 one cycle after release.
REQ-023 Bytes 0x08, 0x05, 0x03 -> MOUSE_X=85, MOUSE_Y=57, MOUSE_STATUS=0x08, one PACKET_VALID pulse 2 cycles after the third BYTE_READY.
REQ-024 Bytes 0x38, 0xF6, 0xFB from (80,60) -> MOUSE_X=70, MOUSE_Y=65.
REQ-025 Clamping:
- From X=150, packet 0x08, 0x14, 0x00 -> MOUSE_X=159.
- From Y=115, packet 0x28, 0x00, 0xEC -> MOUSE_Y=119.
- From X=5, packet 0x18, 0xF0, 0x00 -> MOUSE_X=0.
- Packet 0x48, 0x05, 0x00 (X overflow) -> position unchanged, PACKET_VALID pulses.
REQ-026 Resync and errors:
- Byte 0x00 (bit3 clear), then 0x08, 0x01, 0x00 -> MOUSE_X increments by 1 and no PACKET_ERROR.
- Byte1 with BYTE_ERROR_CODE=01 -> one PACKET_ERROR pulse, position unchanged, next good packet updates normally.
REQ-027 Byte0 0x08, then no byte for TIMEOUT cycles -> one PACKET_ERROR pulse and STATE=0; then 0x08, 0x02, 0x00 -> MOUSE_X increases by 2.
